mul_wb_regif: RTL
=================

# mul_wb_regif

Wishbone register front-end for the 16x16 combinational multiplier in the user project area. The management SoC writes operands and a start command over Wishbone MI A, and the block holds the operands stable on the multiplier inputs. After a programmable settle time it captures the 32-bit product and optionally adds it into an accumulator, then raises done/irq. It sits between the Wishbone slave port of `user_proj_example` and the `fastmul_16x16` instance: it feeds the multiplier and consumes its product.

## Interface
Parameters:
- `BASE_ADDR`, 32'h3000_0000, window base; decode on `wbs_adr_i[31:8] == BASE_ADDR[31:8]`
- `MUL_WAIT`, 2, settle cycles (>=1) between operand launch and product capture

Ports:
- `wb_clk_i` in 1: the single clock
- `wb_rst_ni` in 1: reset, synchronous, active-low
- `wbs_stb_i`, `wbs_cyc_i`, `wbs_we_i` in 1: Wishbone strobe, cycle, write enable
- `wbs_sel_i` in 4: byte selects
- `wbs_adr_i` in 32: byte address
- `wbs_dat_i` in 32: write data
- `wbs_ack_o` out 1: registered acknowledge
- `wbs_dat_o` out 32: registered read data
- `mul_a_o`, `mul_b_o` out 16: multiplier operands
- `mul_y_i` in 32: multiplier product
- `irq_o` out 1: level interrupt
- `busy_o` out 1: computation in progress

## Operation
- Register map (offset[7:0]):
  - 0x00 OPS: RW. a=[15:0], b=[31:16].
  - 0x04 CTRL: write bits are bit0 start (self-clearing), bit1 acc_en, bit2 acc_clr (self-clearing), bit3 irq_en, bit9 done (W1C). Read bits are bit1 acc_en, bit3 irq_en, bit8 busy, bit9 done, bit10 ovf.
  - 0x08 RESULT: RO.
  - 0x0C ACC: RO.
  - Other in-window offsets: writes ignored, reads 0, still acked.
- `wbs_sel_i` honoured per byte on OPS and CTRL writes. Bit0 (start) lives in byte 0, so start requires sel[0].
- `mul_a_o`/`mul_b_o` are driven straight from OPS. OPS writes while busy are acked and discarded.
- FSM IDLE -> CALC on a committed start:
  - Clear done, load counter with MUL_WAIT.
  - In CALC, decrement the counter each cycle. When it reaches 1, capture at the next edge and return to IDLE.
- Capture:
  - RESULT <= `mul_y_i`; set done.
  - If acc_en: ACC <= ACC + `mul_y_i` (32-bit wrap). Set sticky ovf on carry-out.
- acc_clr zeroes ACC and ovf at commit. If acc_clr and start are in the same write, the clear happens first.
- A start while busy is ignored; the other CTRL bits in that write still apply.
- done is cleared by W1C or by a new start.
- `irq_o` = done & irq_en.

## Timing
- Ack:
  - A request is valid when cyc & stb & in-window.
  - `wbs_ack_o` rises one cycle after valid and is a single-cycle pulse (asserted only when valid & !ack).
  - A held strobe gets one ack per two cycles. Out-of-window requests get no ack.
- Write commit happens at the edge where ack is asserted; `wbs_dat_o` is valid in the ack cycle.
- Start committed at edge E0: `busy_o`=1 from E0 until edge E0+MUL_WAIT. RESULT, ACC and done update at E0+MUL_WAIT, and busy clears at the same edge.
- Reading RESULT/ACC while busy returns the previous values.
- Reset (`wb_rst_ni`=0 at an edge):
  - All registers, outputs, FSM (IDLE), counter, ack, `wbs_dat_o` and `irq_o` go to 0.
  - Reset mid-CALC aborts with no capture.
  - An ack pending at reset is dropped.

## Structure
- Package `mul_regif_pkg`: register offsets, CTRL bit indices, FSM state enum (IDLE, CALC).
- Single module, no sub-module. Ack/decode, register file, FSM and accumulator are inline.
- `fastmul_16x16` is instantiated beside this block in `user_proj_example`, not inside it.

## Test plan
- Write OPS=0xFFFF_FFFF, CTRL=0x1; poll → RESULT=0xFFFE_0001, done=1, busy high for exactly MUL_WAIT cycles after the commit edge.
- OPS a=3 b=5, CTRL=0xB (start+acc_en+irq_en) twice, clearing done between → ACC=30, `irq_o` high after each, low after W1C to bit9.
- Accumulate 0xFFFF×0xFFFF twice from ACC=0 → ACC=0xFFFC_0002, ovf=1; CTRL=0x4 → ACC=0, ovf=0.
- Mid-CALC: write OPS=0x0002_0002 and CTRL=0x1 → both acked, ignored; RESULT equals the original operands' product.
- Write OPS with sel=0b0011, data 0xAAAA_1234 → a=0x1234, b unchanged.
- Assert `wb_rst_ni`=0 one cycle after start commit → busy=0, RESULT=0, done=0; no capture afterwards.

Source files
------------

// File: rtl/mul_regif_pkg.sv
// Shared register map, CTRL bit positions and FSM encoding for the
// Wishbone multiplier front-end.
package mul_regif_pkg;

    localparam logic [7:0] OfsOps    = 8'h00;
    localparam logic [7:0] OfsCtrl   = 8'h04;
    localparam logic [7:0] OfsResult = 8'h08;
    localparam logic [7:0] OfsAcc    = 8'h0C;

    localparam int unsigned CtrlStart  = 0;
    localparam int unsigned CtrlAccEn  = 1;
    localparam int unsigned CtrlAccClr = 2;
    localparam int unsigned CtrlIrqEn  = 3;
    localparam int unsigned CtrlBusy   = 8;
    localparam int unsigned CtrlDone   = 9;
    localparam int unsigned CtrlOvf    = 10;

    typedef enum logic {
        StIdle,
        StCalc
    } state_e;

endpackage

// File: rtl/mul_wb_regif.sv
// Wishbone register front-end for an external 16x16 combinational multiplier:
// holds operands, captures the product after a settle delay, optional accumulate.
module mul_wb_regif
    import mul_regif_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned MUL_WAIT  = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [15:0] mul_a_o,
    output logic [15:0] mul_b_o,
    input  logic [31:0] mul_y_i,
    output logic        irq_o,
    output logic        busy_o
);

    localparam int unsigned CntW = $clog2(MUL_WAIT + 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;
    logic [31:0]     ops_q, ops_d;
    logic [31:0]     result_q, result_d;
    logic [31:0]     acc_q, acc_d;
    logic            acc_en_q, acc_en_d;
    logic            irq_en_q, irq_en_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;

    logic        req_valid, commit, wr_ops, wr_ctrl;
    logic        start, acc_clr, done_w1c, capture;
    logic [7:0]  ofs;
    logic [31:0] rdata, acc_base;
    logic        ovf_base;
    logic [32:0] acc_sum;

    assign ofs       = wbs_adr_i[7:0];
    assign req_valid = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // One ack per accepted request; a held strobe drops ack every other cycle.
    assign commit    = req_valid & ~ack_q;
    assign ack_d     = commit;

    assign wr_ops   = commit & wbs_we_i & (ofs == OfsOps) & (state_q == StIdle);
    assign wr_ctrl  = commit & wbs_we_i & (ofs == OfsCtrl);
    assign start    = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[CtrlStart] & (state_q == StIdle);
    assign acc_clr  = wr_ctrl & wbs_sel_i[0] & wbs_dat_i[CtrlAccClr];
    assign done_w1c = wr_ctrl & wbs_sel_i[1] & wbs_dat_i[CtrlDone];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCalc;
                    cnt_d   = CntW'(MUL_WAIT);
                end
            end
            StCalc: begin
                if (cnt_q == CntW'(1)) begin
                    capture = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ops_d = ops_q;
        for (int i = 0; i < 4; i++) begin
            if (wr_ops && wbs_sel_i[i]) ops_d[8*i +: 8] = wbs_dat_i[8*i +: 8];
        end

        acc_en_d = acc_en_q;
        irq_en_d = irq_en_q;
        if (wr_ctrl && wbs_sel_i[0]) begin
            acc_en_d = wbs_dat_i[CtrlAccEn];
            irq_en_d = wbs_dat_i[CtrlIrqEn];
        end

        done_d = done_q;
        if (done_w1c || start) done_d = 1'b0;
        if (capture)           done_d = 1'b1;

        // A clear committed in the capture cycle is applied before the add.
        acc_base = acc_clr ? 32'h0 : acc_q;
        ovf_base = acc_clr ? 1'b0 : ovf_q;
        acc_sum  = {1'b0, acc_base} + {1'b0, mul_y_i};

        result_d = result_q;
        acc_d    = acc_base;
        ovf_d    = ovf_base;
        if (capture) begin
            result_d = mul_y_i;
            if (acc_en_q) begin
                acc_d = acc_sum[31:0];
                ovf_d = ovf_base | acc_sum[32];
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (ofs)
            OfsOps:    rdata = ops_q;
            OfsCtrl: begin
                rdata[CtrlAccEn] = acc_en_q;
                rdata[CtrlIrqEn] = irq_en_q;
                rdata[CtrlBusy]  = (state_q == StCalc);
                rdata[CtrlDone]  = done_q;
                rdata[CtrlOvf]   = ovf_q;
            end
            OfsResult: rdata = result_q;
            OfsAcc:    rdata = acc_q;
            default:   rdata = 32'h0;
        endcase
        dat_d = ack_d ? rdata : 32'h0;
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            dat_q    <= 32'h0;
            ops_q    <= 32'h0;
            result_q <= 32'h0;
            acc_q    <= 32'h0;
            acc_en_q <= 1'b0;
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            ops_q    <= ops_d;
            result_q <= result_d;
            acc_q    <= acc_d;
            acc_en_q <= acc_en_d;
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign mul_a_o   = ops_q[15:0];
    assign mul_b_o   = ops_q[31:16];
    assign irq_o     = done_q & irq_en_q;
    assign busy_o    = (state_q == StCalc);

endmodule
